// File: rtl/board_judge_pkg.sv
// Shared types and constants for the tic-tac-toe board judge.
package board_judge_pkg;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;
    localparam int CELL_AW   = 4;

    // Mark codes stored in each board cell; 2'b01 is not a legal mark.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        MARK_X = 2'b10,
        MARK_O = 2'b11
    } cellStateType;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } fsm_state_e;

    // Cells of each winning line, in scan order: rows, columns, diagonals.
    localparam logic [CELL_AW-1:0] LINE_TABLE [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // True for the two codes a player may place.
    function automatic logic is_mark(input logic [1:0] code);
        return (code == MARK_X) || (code == MARK_O);
    endfunction

endpackage

// File: rtl/board_judge_if.sv
// Bus between the game controller (master) and the board judge (slave).
interface board_judge_if #(
    parameter int NCELLS = 9
);
    logic                  write;
    logic [3:0]            addr;
    logic [1:0]            cellState;
    logic                  ready;
    logic                  writeOk;
    logic                  writeErr;
    logic                  gameIsDone;
    logic [1:0]            winner;
    logic [2*NCELLS-1:0]   gBoard;
    logic [3:0]            moveCount;

    modport master (
        output write, addr, cellState,
        input  ready, writeOk, writeErr, gameIsDone, winner, gBoard, moveCount
    );

    modport slave (
        input  write, addr, cellState,
        output ready, writeOk, writeErr, gameIsDone, winner, gBoard, moveCount
    );
endinterface

// File: rtl/board_judge_line_check.sv
// Decides whether three cells form a completed line and, if so, whose.
module line_check
    import board_judge_pkg::*;
(
    input  logic [1:0] cell_a,
    input  logic [1:0] cell_b,
    input  logic [1:0] cell_c,
    output logic       win,
    output logic [1:0] mark
);

    // A line wins only when all three cells hold the same non-empty mark.
    always_comb begin
        win  = (cell_a != EMPTY) && (cell_a == cell_b) && (cell_b == cell_c);
        mark = win ? cell_a : EMPTY;
    end

endmodule

// File: rtl/board_judge.sv
// Board judge: stores moves, scans one winning line per cycle after each
// accepted move, and latches the game result.
module board_judge
    import board_judge_pkg::*;
#(
    parameter int NCELLS = 9,
    parameter int NLINES = 8
) (
    input  logic           ph1,
    input  logic           reset,
    board_judge_if.slave   bus
);

    localparam int AW = $clog2(NCELLS);
    localparam int LW = $clog2(NLINES);
    localparam logic [3:0]    MAX_ADDR  = 4'(NCELLS - 1);
    localparam logic [3:0]    FULL_CNT  = 4'(NCELLS);
    localparam logic [LW-1:0] LAST_LINE = LW'(NLINES - 1);

    fsm_state_e                state_q, state_d;
    logic [NCELLS-1:0][1:0]    board_q, board_d;
    logic [3:0]                count_q, count_d;
    logic [LW-1:0]             line_idx_q, line_idx_d;
    logic [1:0]                winner_q, winner_d;
    logic                      done_q, done_d;
    logic                      ok_q, ok_d;
    logic                      err_q, err_d;

    logic                      line_win;
    logic [1:0]                line_mark;
    logic                      write_bad;

    // Single checker shared by all lines; lineIdx picks which cells feed it.
    line_check u_line_check (
        .cell_a (board_q[LINE_TABLE[line_idx_q][0][AW-1:0]]),
        .cell_b (board_q[LINE_TABLE[line_idx_q][1][AW-1:0]]),
        .cell_c (board_q[LINE_TABLE[line_idx_q][2][AW-1:0]]),
        .win    (line_win),
        .mark   (line_mark)
    );

    // Classify an incoming write: bad address, illegal mark, or occupied cell.
    always_comb begin
        write_bad = 1'b0;
        if (bus.addr > MAX_ADDR) begin
            write_bad = 1'b1;
        end else if (!is_mark(bus.cellState)) begin
            write_bad = 1'b1;
        end else if (board_q[bus.addr[AW-1:0]] != EMPTY) begin
            write_bad = 1'b1;
        end
    end

    // Next-state and next-output logic for the IDLE/CHECK/DONE controller.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned and infers a latch.
        state_d    = state_q;
        board_d    = board_q;
        count_d    = count_q;
        line_idx_d = line_idx_q;
        winner_d   = winner_q;
        done_d     = done_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.write) begin
                    if (write_bad) begin
                        err_d = 1'b1;
                    end else begin
                        board_d[bus.addr[AW-1:0]] = bus.cellState;
                        count_d    = count_q + 4'd1;
                        ok_d       = 1'b1;
                        line_idx_d = '0;
                        state_d    = CHECK;
                    end
                end
            end
            CHECK: begin
                // Writes arriving while scanning are dropped silently.
                if (line_win) begin
                    winner_d = line_mark;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (line_idx_q == LAST_LINE) begin
                    line_idx_d = '0;
                    if (count_q == FULL_CNT) begin
                        winner_d = EMPTY;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    line_idx_d = line_idx_q + 1'b1;
                end
            end
            DONE: begin
                // The game is over; every further write is refused.
                if (bus.write) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            // NOTE: the board is a small flop array, not a RAM, so it is reset so gBoard reads all-EMPTY.
            state_q    <= IDLE;
            board_q    <= '0;
            count_q    <= '0;
            line_idx_q <= '0;
            winner_q   <= EMPTY;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q    <= state_d;
            board_q    <= board_d;
            count_q    <= count_d;
            line_idx_q <= line_idx_d;
            winner_q   <= winner_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign bus.ready      = (state_q == IDLE);
    assign bus.writeOk    = ok_q;
    assign bus.writeErr   = err_q;
    assign bus.gameIsDone = done_q;
    assign bus.winner     = winner_q;
    assign bus.gBoard     = board_q;
    assign bus.moveCount  = count_q;

endmodule

// File: tb/tb_board_judge.sv
// Self-checking bench for board_judge: a vector table for one full game
// plus directed sequences for row win, draw, CHECK-time writes and reset.
module tb_board_judge;

    localparam logic [1:0] CX = 2'b10;
    localparam logic [1:0] CO = 2'b11;

    logic ph1;
    logic reset;

    board_judge_if #(.NCELLS(9)) bus ();

    board_judge #(.NCELLS(9), .NLINES(8)) dut (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [17:0] model_board;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [1:0] cs;
        logic       ok;
        logic       err;
        int         wait_n;
        logic       rdy;
        logic       done;
        logic [1:0] win;
        logic [3:0] cnt;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic apply_reset();
        bus.write     = 1'b0;
        bus.addr      = 4'd0;
        bus.cellState = 2'b00;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_board = '0;
    endtask

    // Place a legal mark; optionally let the 8-cycle scan finish.
    task automatic move(input logic [3:0] a, input logic [1:0] cs, input logic full_wait, input string tag);
        bus.write     = 1'b1;
        bus.addr      = a;
        bus.cellState = cs;
        tick();
        bus.write = 1'b0;
        check({tag, " writeOk"}, bus.writeOk, 1'b1);
        model_board[2*a +: 2] = cs;
        if (full_wait) begin
            repeat (8) tick();
            check({tag, " ready"}, bus.ready, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // One game: rejections of every kind, then an O diagonal on line 7.
        vecs[0]  = '{1'b1, 4'd0,  CX,    1'b1, 1'b0, 8, 1'b1, 1'b0, 2'b00, 4'd1};
        vecs[1]  = '{1'b1, 4'd2,  CO,    1'b1, 1'b0, 8, 1'b1, 1'b0, 2'b00, 4'd2};
        vecs[2]  = '{1'b1, 4'd1,  CX,    1'b1, 1'b0, 8, 1'b1, 1'b0, 2'b00, 4'd3};
        vecs[3]  = '{1'b1, 4'd0,  CO,    1'b0, 1'b1, 0, 1'b1, 1'b0, 2'b00, 4'd3};
        vecs[4]  = '{1'b1, 4'd9,  CX,    1'b0, 1'b1, 0, 1'b1, 1'b0, 2'b00, 4'd3};
        vecs[5]  = '{1'b1, 4'd5,  2'b01, 1'b0, 1'b1, 0, 1'b1, 1'b0, 2'b00, 4'd3};
        vecs[6]  = '{1'b1, 4'd5,  2'b00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 2'b00, 4'd3};
        vecs[7]  = '{1'b1, 4'd15, CO,    1'b0, 1'b1, 0, 1'b1, 1'b0, 2'b00, 4'd3};
        vecs[8]  = '{1'b1, 4'd4,  CO,    1'b1, 1'b0, 8, 1'b1, 1'b0, 2'b00, 4'd4};
        vecs[9]  = '{1'b1, 4'd3,  CX,    1'b1, 1'b0, 8, 1'b1, 1'b0, 2'b00, 4'd5};
        vecs[10] = '{1'b1, 4'd6,  CO,    1'b1, 1'b0, 7, 1'b0, 1'b0, 2'b00, 4'd6};
        vecs[11] = '{1'b0, 4'd0,  2'b00, 1'b0, 1'b0, 0, 1'b0, 1'b1, CO,    4'd6};
        vecs[12] = '{1'b1, 4'd8,  CX,    1'b0, 1'b1, 0, 1'b0, 1'b1, CO,    4'd6};
        vecs[13] = '{1'b0, 4'd0,  2'b00, 1'b0, 1'b0, 0, 1'b0, 1'b1, CO,    4'd6};

        apply_reset();
        check("reset ready",     bus.ready,      1'b1);
        check("reset done",      bus.gameIsDone, 1'b0);
        check("reset winner",    bus.winner,     2'b00);
        check("reset gBoard",    bus.gBoard,     18'd0);
        check("reset moveCount", bus.moveCount,  4'd0);
        check("reset writeOk",   bus.writeOk,    1'b0);
        check("reset writeErr",  bus.writeErr,   1'b0);

        for (int i = 0; i < NV; i++) begin
            bus.write     = vecs[i].wr;
            bus.addr      = vecs[i].addr;
            bus.cellState = vecs[i].cs;
            tick();
            bus.write = 1'b0;
            check($sformatf("v%0d writeOk", i),  bus.writeOk,  vecs[i].ok);
            check($sformatf("v%0d writeErr", i), bus.writeErr, vecs[i].err);
            if (vecs[i].ok) model_board[2*vecs[i].addr +: 2] = vecs[i].cs;
            check($sformatf("v%0d gBoard", i), bus.gBoard, model_board);
            repeat (vecs[i].wait_n) tick();
            check($sformatf("v%0d ready", i),     bus.ready,      vecs[i].rdy);
            check($sformatf("v%0d done", i),      bus.gameIsDone, vecs[i].done);
            check($sformatf("v%0d winner", i),    bus.winner,     vecs[i].win);
            check($sformatf("v%0d moveCount", i), bus.moveCount,  vecs[i].cnt);
        end
        check("diag final gBoard", bus.gBoard, 18'b00_00_11_00_11_10_11_10_10);

        // Row-0 X win one edge after the fifth accept; a write during CHECK is dropped.
        apply_reset();
        move(4'd0, CX, 1'b1, "row m1");
        move(4'd3, CO, 1'b1, "row m2");
        move(4'd1, CX, 1'b0, "row m3");
        bus.write     = 1'b1;
        bus.addr      = 4'd5;
        bus.cellState = CO;
        tick();
        bus.write = 1'b0;
        check("check-write writeOk",  bus.writeOk,  1'b0);
        check("check-write writeErr", bus.writeErr, 1'b0);
        check("check-write gBoard",   bus.gBoard,   model_board);
        repeat (7) tick();
        check("check-write ready", bus.ready,     1'b1);
        check("check-write count", bus.moveCount, 4'd3);
        move(4'd4, CO, 1'b1, "row m4");
        move(4'd2, CX, 1'b0, "row m5");
        check("row done at accept", bus.gameIsDone, 1'b0);
        tick();
        check("row done",      bus.gameIsDone, 1'b1);
        check("row winner",    bus.winner,     CX);
        check("row moveCount", bus.moveCount,  4'd5);
        check("row ready",     bus.ready,      1'b0);
        repeat (3) tick();
        check("row hold winner", bus.winner, CX);
        check("row hold gBoard", bus.gBoard, model_board);

        // Draw: X O X / X O O / O X X.
        apply_reset();
        move(4'd0, CX, 1'b1, "draw m1");
        move(4'd1, CO, 1'b1, "draw m2");
        move(4'd2, CX, 1'b1, "draw m3");
        move(4'd3, CX, 1'b1, "draw m4");
        move(4'd4, CO, 1'b1, "draw m5");
        move(4'd5, CO, 1'b1, "draw m6");
        move(4'd6, CO, 1'b1, "draw m7");
        move(4'd7, CX, 1'b1, "draw m8");
        move(4'd8, CX, 1'b0, "draw m9");
        repeat (7) tick();
        check("draw early done",  bus.gameIsDone, 1'b0);
        check("draw early ready", bus.ready,      1'b0);
        tick();
        check("draw done",      bus.gameIsDone, 1'b1);
        check("draw winner",    bus.winner,     2'b00);
        check("draw moveCount", bus.moveCount,  4'd9);
        check("draw ready",     bus.ready,      1'b0);
        check("draw gBoard",    bus.gBoard,     18'b10_10_11_11_11_10_10_11_10);

        // Reset in the middle of a scan after three moves.
        apply_reset();
        move(4'd0, CX, 1'b1, "rst m1");
        move(4'd1, CO, 1'b1, "rst m2");
        move(4'd2, CX, 1'b0, "rst m3");
        tick();
        tick();
        check("rst pre ready", bus.ready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("rst async gBoard", bus.gBoard,     18'd0);
        check("rst async count",  bus.moveCount,  4'd0);
        check("rst async done",   bus.gameIsDone, 1'b0);
        check("rst async winner", bus.winner,     2'b00);
        check("rst async ok",     bus.writeOk,    1'b0);
        check("rst async err",    bus.writeErr,   1'b0);
        #1;
        reset = 1'b0;
        model_board = '0;
        check("rst ready", bus.ready, 1'b1);
        move(4'd4, CO, 1'b0, "rst post");
        check("rst post count",  bus.moveCount, 4'd1);
        check("rst post gBoard", bus.gBoard,    model_board);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
